// File: rtl/pattern_tx_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
// PATTERN/PAT_LEN double as the golden frame for the sequence-detector bench.
package pattern_tx_pkg;

  localparam int unsigned PAT_LEN = 12;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned IDX_W   = 4;

  localparam logic [PAT_LEN-1:0] PATTERN  = 12'b1010_1111_1000;
  // Corrupts bit 6 so the detector must reject the frame.
  localparam logic [PAT_LEN-1:0] ERR_MASK = 12'b0000_0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_tx_if.sv
// Control/status bundle of pattern_tx; err_inject exists only when
// PATTERN_TX_ERR_INJECT_EN is defined.
interface pattern_tx_if;
  import pattern_tx_pkg::*;

  logic             start;
  logic [CNT_W-1:0] frames;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
`ifdef PATTERN_TX_ERR_INJECT_EN
  logic             err_inject;
`endif
  logic             z;
  logic             busy;
  logic             frame_tick;
  logic             done;
  logic [CNT_W-1:0] frame_count;

  modport master (
`ifdef PATTERN_TX_ERR_INJECT_EN
    output err_inject,
`endif
    output start, frames, gap_len, abort,
    input  z, busy, frame_tick, done, frame_count
  );

  modport slave (
`ifdef PATTERN_TX_ERR_INJECT_EN
    input  err_inject,
`endif
    input  start, frames, gap_len, abort,
    output z, busy, frame_tick, done, frame_count
  );

endinterface

// File: rtl/pattern_tx_shift.sv
// pattern_shift: loadable MSB-first frame shift register; its MSB is the line z.
// Shifting in zeros leaves the register clear once a frame has been fully sent.
module pattern_shift
  import pattern_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic inv_i,
  input  logic shift_i,
  input  logic clear_i,
  output logic z_o
);

  logic [PAT_LEN-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = inv_i ? (PATTERN ^ ERR_MASK) : PATTERN;
    end else if (shift_i) begin
      sr_d = {sr_q[PAT_LEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign z_o = sr_q[PAT_LEN-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends PATTERN 'frames' times with gap_len+1 idle
// bits between frames. Optional PATTERN_TX_ERR_INJECT_EN adds per-frame corruption.
module pattern_tx
  import pattern_tx_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  pattern_tx_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             sh_load, sh_shift, sh_clear, sh_inv;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count_q + CNT_W'(1);

`ifdef PATTERN_TX_ERR_INJECT_EN
  assign sh_inv = bus.err_inject;
`else
  assign sh_inv = 1'b0;
`endif

  // Next-state and registered-output decode; abort outranks frame completion.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    frames_d  = frames_q;
    count_d   = count_q;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = '0;
          if (bus.frames != '0) begin
            frames_d  = bus.frames;
            gap_len_d = bus.gap_len;
            bit_idx_d = IDX_W'(PAT_LEN - 1);
            sh_load   = 1'b1;
            busy_d    = 1'b1;
            state_d   = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          sh_clear = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
          sh_shift  = 1'b1;
        end else begin
          sh_shift = 1'b1;
          count_d  = count_inc;
          tick_d   = 1'b1;
          if (count_inc == frames_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          sh_clear = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (gap_cnt_q == '0) begin
          bit_idx_d = IDX_W'(PAT_LEN - 1);
          sh_load   = 1'b1;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        sh_clear = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      frames_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      frames_q  <= frames_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  pattern_shift u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sh_load),
    .inv_i   (sh_inv),
    .shift_i (sh_shift),
    .clear_i (sh_clear),
    .z_o     (bus.z)
  );

  assign bus.busy        = busy_q;
  assign bus.frame_tick  = tick_q;
  assign bus.done        = done_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized bench for pattern_tx against a frame-list reference model;
// also counts detector hits on the observed z stream.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pattern_tx_if bus();

  pattern_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One transfer: n frames, gap g, abort during cycle ab (-1 none), corrupt frame inj (-1 none).
  // Cycle k=0 is the first cycle after the edge that accepts start.
  task automatic run_xfer(input int n, input int g, input int ab, input int inj);
    int zq[$];
    int ends[$];
    int len, lim, det, exp_det;
    int ez, eb, et, ed, ec, lastk;
    logic [PAT_LEN-1:0] fp, win, pat;
`ifndef PATTERN_TX_ERR_INJECT_EN
    inj = -1;
`endif
    pat = PATTERN;
    for (int f = 0; f < n; f++) begin
      fp = pat;
      if (f == inj) fp[6] = ~fp[6];
      for (int b = PAT_LEN - 1; b >= 0; b--) zq.push_back(int'(fp[b]));
      ends.push_back(zq.size());
      if (f < n - 1) for (int j = 0; j <= g; j++) zq.push_back(0);
    end
    len = zq.size();
    lim = (ab >= 0) ? ab + 2 : len + 1;

    @(negedge clk);
    bus.frames  = 8'(n);
    bus.gap_len = 4'(g);
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
`ifdef PATTERN_TX_ERR_INJECT_EN
    bus.err_inject = (inj == 0);
`endif
    @(negedge clk);
    win = '0;
    det = 0;
    for (int k = 0; k <= lim; k++) begin
      lastk = (ab >= 0 && k > ab) ? ab : k;
      ec = 0;
      et = 0;
      foreach (ends[i]) begin
        if (ends[i] <= lastk) ec++;
        if (ends[i] == k) et = 1;
      end
      if (ab >= 0 && k > ab) begin
        ez = 0; eb = 0; et = 0; ed = 0;
      end else begin
        ez = (k < len) ? zq[k] : 0;
        eb = (k < len) ? 1 : 0;
        ed = (k == len) ? 1 : 0;
      end
      check_eq($sformatf("z@%0d", k),     32'(bus.z),           32'(ez));
      check_eq($sformatf("busy@%0d", k),  32'(bus.busy),        32'(eb));
      check_eq($sformatf("tick@%0d", k),  32'(bus.frame_tick),  32'(et));
      check_eq($sformatf("done@%0d", k),  32'(bus.done),        32'(ed));
      check_eq($sformatf("count@%0d", k), 32'(bus.frame_count), 32'(ec));
      win = {win[PAT_LEN-2:0], bus.z};
      if (win == pat) det++;
      // Stimulus for the next edge: start/frames/gap noise is ignored while active.
      bus.start   = ((ab < 0 && k <= len) || (ab >= 0 && k <= ab)) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.frames  = 8'($urandom);
      bus.gap_len = 4'($urandom);
      bus.abort   = (ab >= 0) ? (k == ab) : (k == len && $urandom_range(0, 1) == 1);
`ifdef PATTERN_TX_ERR_INJECT_EN
      bus.err_inject = 1'($urandom_range(0, 1));
      foreach (ends[i]) begin
        if (ends[i] - PAT_LEN == k + 1) bus.err_inject = (i == inj);
      end
`endif
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (ab < 0) begin
      exp_det = n - ((inj >= 0 && inj < n) ? 1 : 0);
      check_eq($sformatf("detect n=%0d", n), 32'(det), 32'(exp_det));
    end
  endtask

  int n, g, ab, inj, len;

  initial begin
    bus.start   = 1'b0;
    bus.frames  = '0;
    bus.gap_len = '0;
    bus.abort   = 1'b0;
`ifdef PATTERN_TX_ERR_INJECT_EN
    bus.err_inject = 1'b0;
`endif
    reset = 1'b1;
    #12;
    check_eq("rst_z",     32'(bus.z),           32'd0);
    check_eq("rst_busy",  32'(bus.busy),        32'd0);
    check_eq("rst_tick",  32'(bus.frame_tick),  32'd0);
    check_eq("rst_done",  32'(bus.done),        32'd0);
    check_eq("rst_count", 32'(bus.frame_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_xfer(1, 0, -1, -1);
    run_xfer(3, 0, -1, -1);
    run_xfer(2, 5, -1, -1);
    run_xfer(0, 3, -1, -1);
    run_xfer(4, 1, 18, -1);   // cycle 5 of frame 2
    run_xfer(1, 0, -1, -1);
    run_xfer(1, 0, 11, -1);   // abort on the last bit beats completion
    run_xfer(2, 15, 20, -1);  // abort inside the gap
    run_xfer(3, 0, -1, 1);
    run_xfer(255, 0, -1, -1);

    for (int t = 0; t < 12; t++) begin
      n   = $urandom_range(0, 5);
      g   = $urandom_range(0, 15);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : -1;
      len = (n == 0) ? 0 : n * PAT_LEN + (n - 1) * (g + 1);
      ab  = -1;
      if (len > 0 && $urandom_range(0, 2) == 0) begin
        for (int r = 0; r < 50; r++) begin
          ab = $urandom_range(0, len - 1);
          if (((ab + 1) % (PAT_LEN + g + 1)) != PAT_LEN) break;
        end
        if (((ab + 1) % (PAT_LEN + g + 1)) == PAT_LEN) ab = -1;
      end
      run_xfer(n, g, ab, inj);
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    bus.frames  = 8'd2;
    bus.gap_len = 4'd0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("pre_rst_z", 32'(bus.z), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_z",     32'(bus.z),           32'd0);
    check_eq("mid_rst_busy",  32'(bus.busy),        32'd0);
    check_eq("mid_rst_tick",  32'(bus.frame_tick),  32'd0);
    check_eq("mid_rst_done",  32'(bus.done),        32'd0);
    check_eq("mid_rst_count", 32'(bus.frame_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_xfer(1, 2, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit line z consumed by the team's 12-bit sequence detector (FSM3). On a start request it emits the detection pattern 1,0,1,0,1,1,1,1,1,0,0,0 (MSB first) a programmable number of times, with a programmable idle gap between frames. It stimulates the detector in the lab design and is the source side of the same serial link.

Parameters:
PATTERN, 12'b101011111000, frame bits, transmitted MSB (bit 11) first
PAT_LEN, 12, frame length in bits
CNT_W, 8, width of frame-count request and report
GAP_W, 4, width of gap-length request

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces all state and outputs to reset values
start  input  1  request; sampled in IDLE only
frames  input  CNT_W  number of frames to send; captured on accepted start
gap_len  input  GAP_W  extra idle bits between frames; captured on accepted start
abort  input  1  synchronous abort of an active transfer
z  output  1  serial data line, registered
busy  output  1  high in SEND and GAP
frame_tick  output  1  one-cycle pulse, cycle after the last bit of each frame
done  output  1  one-cycle pulse at normal completion
frame_count  output  CNT_W  frames fully sent in current/last transfer

Behaviour:
- Reset values: z=0, busy=0, frame_tick=0, done=0, frame_count=0, state IDLE, counters 0.
- States: IDLE, SEND, GAP, DONE. All outputs are registered, with no combinational path from inputs to outputs.
- IDLE:
  - start=1 and frames!=0: latch frames and gap_len, frame_count<=0, bit_idx<=PAT_LEN-1, z<=PATTERN[11], go to SEND. z is valid the same edge start is sampled.
  - start=1 and frames==0: go to DONE directly (done pulse, frame_count=0, z stays 0).
- SEND: each edge, bit_idx decrements and z<=PATTERN[bit_idx-1]. The edge after bit 0 has been shown:
  - frame_count+1 and frame_tick=1 for one cycle.
  - If the new count equals the latched frames, go to DONE.
  - Otherwise go to GAP with gap counter=gap_len and z<=0.
- GAP:
  - z=0 for gap_len+1 cycles in total. The minimum gap of one bit is mandatory because the detector ignores z for the cycle after a detection.
  - Then reload bit_idx, drive PATTERN[11], and return to SEND.
- DONE: z=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start while busy or in DONE is ignored. frames and gap_len changes after capture have no effect.
- abort=1 in SEND or GAP:
  - Next edge: z<=0, go to IDLE.
  - No done pulse and no frame_tick for the partial frame.
  - frame_count keeps completed frames.
- abort in IDLE or DONE has no effect.
- abort and completion on the same edge: abort wins, so no done pulse.
- frame_count saturates naturally: it cannot exceed frames ≤ 2^CNT_W−1, so there is no wrap.
- Asynchronous reset mid-transfer: immediate return to reset values; z drops to 0 without waiting for a clock.

Optional Feature:
PATTERN_TX_ERR_INJECT_EN
- Defined: adds input err_inject (1 bit), sampled on the edge that loads bit 11 of a frame. When it is high, that frame transmits PATTERN with bit 6 inverted, so the detector must not count it. Framing, frame_tick and frame_count are unchanged.
- Undefined: the port is absent and every frame is the exact PATTERN.

Decomposition:
- Shared package pattern_tx_pkg holds:
  - state encoding: IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3
  - PATTERN and PAT_LEN constants, also used by the detector bench as the golden pattern
- One natural sub-module, pattern_shift: a loadable PAT_LEN-bit MSB-first shift register with a load/invert control, producing z.
- Counters and the FSM stay in the top module.

Test Plan:
- Single frame: frames=1, gap_len=0, one start pulse → z = 1,0,1,0,1,1,1,1,1,0,0,0 over 12 cycles, then done=1 for 1 cycle. busy high exactly 12 cycles, frame_count=1, frame_tick 1 pulse.
- Back-to-back: frames=3, gap_len=0 → 38 busy cycles (12+1+12+1+12) with a single 0 between frames. Detector count=3, frame_count=3, 3 frame_ticks, 1 done.
- Gap: frames=2, gap_len=5 → 6 zero cycles between frames, 30 busy cycles in total.
- Zero frames: frames=0, start → no busy, done pulse on next cycle, z stays 0, frame_count=0.
- Abort: frames=4, gap_len=1, abort asserted on cycle 5 of frame 2 → next edge z=0 and IDLE, frame_count=1, no done. A following start with frames=1 completes normally.
- Reset/ignore: assert reset mid-frame → z=0 immediately and all outputs 0. start pulsed while busy is ignored, with no change in frame sequence. With PATTERN_TX_ERR_INJECT_EN, err_inject on frame 2 of 3 → detector counts 2, frame_count=3.
